// File: rtl/spk_in_dispatch_pkg.sv
// Shared node definitions: flit type field width, type codes and flit classification.
package spk_in_dispatch_pkg;

  localparam int unsigned NODE_FTW = 3;

  localparam logic [NODE_FTW-1:0] FT_SPIKE  = 3'b000;
  localparam logic [NODE_FTW-1:0] FT_CFG_LO = 3'b001;
  localparam logic [NODE_FTW-1:0] FT_CFG_HI = 3'b110;
  localparam logic [NODE_FTW-1:0] FT_RSVD   = 3'b111;

  typedef enum logic [1:0] {
    KIND_SPIKE = 2'd0,
    KIND_CFG   = 2'd1,
    KIND_RSVD  = 2'd2
  } flit_kind_e;

  function automatic flit_kind_e classify(input logic [NODE_FTW-1:0] ftype);
    flit_kind_e kind;
    kind = KIND_RSVD;
    if (ftype == FT_SPIKE) begin
      kind = KIND_SPIKE;
    end else if (ftype >= FT_CFG_LO && ftype <= FT_CFG_HI) begin
      kind = KIND_CFG;
    end
    return kind;
  endfunction

endpackage

// File: rtl/spk_in_fifo.sv
// Power-of-two FIFO with wrap-bit pointers; push on full is legal only with a same-cycle pop.
module spk_in_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Same index with differing wrap bits means every slot is occupied.
  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/spk_in_dispatch.sv
// Router ingress: spikes to a 2-entry skid buffer toward the axon, config flits to a
// credit-gated FIFO toward the config controller, reserved flits dropped and counted.
module spk_in_dispatch
  import spk_in_dispatch_pkg::*;
#(
  parameter int unsigned FW         = 59,
  parameter int unsigned FTW        = NODE_FTW,
  parameter int unsigned CFG_DEPTH  = 4,
  parameter int unsigned CREDIT_NUM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [FW-1:0] in_flit,
  output logic          in_rdy,
  output logic          spk_in_config_we,
  output logic [FW-1:0] spk_in_config_wdata,
  input  logic          config_spk_in_credit,
  output logic          spk_axon_vld,
  output logic [FW-1:0] spk_axon_data,
  input  logic          axon_spk_rdy,
  output logic [7:0]    drop_cnt,
  output logic          credit_err
);

  localparam int unsigned CW = $clog2(CREDIT_NUM + 1);

  flit_kind_e    kind;
  logic          spk_push;
  logic          spk_pop;
  logic          skid_vld;
  logic [FW-1:0] skid_data;
  logic          cfg_push;
  logic          cfg_pop;
  logic          cfg_full;
  logic          cfg_empty;
  logic [FW-1:0] cfg_head;
  logic          rsvd_acc;
  logic [CW-1:0] credit_cnt;

  // Ready is per flit type; a full buffer still accepts when it is draining this cycle.
  always_comb begin
    kind     = classify(NODE_FTW'(in_flit[FW-1 -: FTW]));
    spk_pop  = spk_axon_vld && axon_spk_rdy;
    cfg_pop  = !cfg_empty && (credit_cnt != '0);
    in_rdy   = 1'b1;
    case (kind)
      KIND_SPIKE: in_rdy = !skid_vld || spk_pop;
      KIND_CFG:   in_rdy = !cfg_full || cfg_pop;
      default:    in_rdy = 1'b1;
    endcase
    spk_push = in_vld && in_rdy && (kind == KIND_SPIKE);
    cfg_push = in_vld && in_rdy && (kind == KIND_CFG);
    rsvd_acc = in_vld && in_rdy && (kind == KIND_RSVD);
  end

  // Spike skid buffer: output register is the head, skid register the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_axon_vld  <= 1'b0;
      spk_axon_data <= '0;
      skid_vld      <= 1'b0;
      skid_data     <= '0;
    end else if (spk_pop) begin
      if (skid_vld) begin
        spk_axon_data <= skid_data;
        skid_vld      <= spk_push;
        if (spk_push) skid_data <= in_flit;
      end else begin
        spk_axon_vld <= spk_push;
        if (spk_push) spk_axon_data <= in_flit;
      end
    end else if (spk_push) begin
      if (spk_axon_vld) begin
        skid_vld  <= 1'b1;
        skid_data <= in_flit;
      end else begin
        spk_axon_vld  <= 1'b1;
        spk_axon_data <= in_flit;
      end
    end
  end

  spk_in_fifo #(
    .W     (FW),
    .DEPTH (CFG_DEPTH)
  ) u_cfg_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cfg_push),
    .wdata (in_flit),
    .pop   (cfg_pop),
    .rdata (cfg_head),
    .full  (cfg_full),
    .empty (cfg_empty)
  );

  // Config strobe; wdata only moves on a pop so it holds while we is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_in_config_we    <= 1'b0;
      spk_in_config_wdata <= '0;
    end else begin
      spk_in_config_we <= cfg_pop;
      if (cfg_pop) spk_in_config_wdata <= cfg_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= CW'(CREDIT_NUM);
      credit_err <= 1'b0;
    end else begin
      case ({cfg_pop, config_spk_in_credit})
        2'b10: credit_cnt <= credit_cnt - CW'(1);
        2'b01: begin
          if (credit_cnt == CW'(CREDIT_NUM)) credit_err <= 1'b1;
          else                               credit_cnt <= credit_cnt + CW'(1);
        end
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (rsvd_acc && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_spk_in_dispatch.sv
// Directed bench for spk_in_dispatch with a queue-based reference model checked every cycle.
module tb_spk_in_dispatch;

  localparam int FW         = 59;
  localparam int CFG_DEPTH  = 4;
  localparam int CREDIT_NUM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_vld = 1'b0;
  logic [FW-1:0] in_flit = '0;
  logic          in_rdy;
  logic          spk_in_config_we;
  logic [FW-1:0] spk_in_config_wdata;
  logic          config_spk_in_credit = 1'b0;
  logic          spk_axon_vld;
  logic [FW-1:0] spk_axon_data;
  logic          axon_spk_rdy = 1'b1;
  logic [7:0]    drop_cnt;
  logic          credit_err;

  always #5 clk = ~clk;

  spk_in_dispatch #(
    .FW         (FW),
    .FTW        (3),
    .CFG_DEPTH  (CFG_DEPTH),
    .CREDIT_NUM (CREDIT_NUM)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_vld               (in_vld),
    .in_flit              (in_flit),
    .in_rdy               (in_rdy),
    .spk_in_config_we     (spk_in_config_we),
    .spk_in_config_wdata  (spk_in_config_wdata),
    .config_spk_in_credit (config_spk_in_credit),
    .spk_axon_vld         (spk_axon_vld),
    .spk_axon_data        (spk_axon_data),
    .axon_spk_rdy         (axon_spk_rdy),
    .drop_cnt             (drop_cnt),
    .credit_err           (credit_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  int spk_cnt = 0;
  bit started = 1'b0;

  // Reference model state
  logic [FW-1:0] m_spk[$];
  logic [FW-1:0] m_cfg[$];
  int            m_credit = CREDIT_NUM;
  bit            m_we = 1'b0;
  logic [FW-1:0] m_wdata = '0;
  int            m_drop = 0;
  bit            m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = spike, 1 = config, 2 = reserved
  function automatic int kind_of(input logic [FW-1:0] f);
    logic [2:0] t;
    t = f[FW-1 -: 3];
    if (t == 3'b000) return 0;
    if (t == 3'b111) return 2;
    return 1;
  endfunction

  function automatic bit exp_rdy();
    int k;
    k = kind_of(in_flit);
    if (k == 0) return (m_spk.size() < 2) || axon_spk_rdy;
    if (k == 1) return (m_cfg.size() < CFG_DEPTH) || (m_credit > 0);
    return 1'b1;
  endfunction

  function automatic logic [FW-1:0] mk(input logic [2:0] t, input int payload);
    logic [FW-1:0] f;
    f = {t, 56'(payload)};
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit sp, cp, acc;
    int k;
    if (!rst_n) begin
      m_spk.delete();
      m_cfg.delete();
      m_credit = CREDIT_NUM;
      m_we     = 1'b0;
      m_wdata  = '0;
      m_drop   = 0;
      m_err    = 1'b0;
    end else begin
      k   = kind_of(in_flit);
      acc = in_vld && exp_rdy();
      sp  = (m_spk.size() > 0) && axon_spk_rdy;
      cp  = (m_cfg.size() > 0) && (m_credit > 0);
      if (sp) void'(m_spk.pop_front());
      m_we = cp;
      if (cp) m_wdata = m_cfg.pop_front();
      if (acc && k == 0) m_spk.push_back(in_flit);
      if (acc && k == 1) m_cfg.push_back(in_flit);
      if (acc && k == 2 && m_drop < 255) m_drop++;
      if (config_spk_in_credit && !cp) begin
        if (m_credit == CREDIT_NUM) m_err = 1'b1;
        else m_credit++;
      end else if (cp && !config_spk_in_credit) begin
        m_credit--;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_rdy", 64'(in_rdy), 64'(exp_rdy()));
      chk("spk_vld", 64'(spk_axon_vld), 64'(m_spk.size() > 0));
      if (m_spk.size() > 0) chk("spk_data", 64'(spk_axon_data), 64'(m_spk[0]));
      chk("cfg_we", 64'(spk_in_config_we), 64'(m_we));
      chk("cfg_wdata", 64'(spk_in_config_wdata), 64'(m_wdata));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("credit_err", 64'(credit_err), 64'(m_err));
      if (spk_in_config_we) we_cnt++;
      if (spk_axon_vld && axon_spk_rdy) spk_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FW-1:0] f);
    int t;
    in_vld  = 1'b1;
    in_flit = f;
    for (t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_rdy) break;
    end
    chk("send_accept", 64'(t < 64), 64'd1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic credit_pulse();
    config_spk_in_credit = 1'b1;
    tick();
    config_spk_in_credit = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int w0, s0;
    #2 rst_n = 1'b0;
    started = 1'b1;
    #1;
    chk("rst_we", 64'(spk_in_config_we), 64'd0);
    chk("rst_spk_vld", 64'(spk_axon_vld), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Six config flits with no credit returned: four strobes, two parked
    w0 = we_cnt;
    for (int i = 0; i < 6; i++) send(mk(3'(i % 6 + 1), 'h100 + i));
    tick(10);
    chk("no_credit_we_pulses", 64'(we_cnt - w0), 64'd4);
    chk("model_cfg_held", 64'(m_cfg.size()), 64'd2);
    in_flit = mk(3'b010, 'h1ff);
    #1;
    chk("cfg_rdy_with_held", 64'(in_rdy), 64'd1);
    tick();

    // Two credits release the parked flits in order
    repeat (2) begin
      credit_pulse();
      tick(2);
    end
    tick(3);
    chk("credit_we_pulses", 64'(we_cnt - w0), 64'd6);
    chk("model_credit_zero", 64'(m_credit), 64'd0);

    // Credit and pop in one cycle leave the counter at 1, then overflow on the 5th
    credit_pulse();
    in_vld  = 1'b1;
    in_flit = mk(3'b011, 'h200);
    tick();
    in_vld = 1'b0;
    config_spk_in_credit = 1'b1;
    tick();
    config_spk_in_credit = 1'b0;
    tick(2);
    repeat (3) credit_pulse();
    chk("credit_err_at_full", 64'(credit_err), 64'd0);
    chk("model_credit_full", 64'(m_credit), 64'(CREDIT_NUM));
    credit_pulse();
    chk("credit_err_overflow", 64'(credit_err), 64'd1);

    // Spike back-pressure: two buffered, spike blocked, config still accepted
    s0 = spk_cnt;
    axon_spk_rdy = 1'b0;
    send(mk(3'b000, 'h301));
    send(mk(3'b000, 'h302));
    in_vld  = 1'b1;
    in_flit = mk(3'b000, 'h303);
    #1;
    chk("spk_full_rdy", 64'(in_rdy), 64'd0);
    tick(2);
    in_flit = mk(3'b100, 'h304);
    #1;
    chk("cfg_rdy_spk_full", 64'(in_rdy), 64'd1);
    send(mk(3'b100, 'h304));
    axon_spk_rdy = 1'b1;
    send(mk(3'b000, 'h303));
    send(mk(3'b000, 'h305));
    send(mk(3'b000, 'h306));
    tick(5);
    chk("spk_delivered", 64'(spk_cnt - s0), 64'd5);

    // Reserved flood saturates the drop counter with no side effects
    w0 = we_cnt;
    s0 = spk_cnt;
    for (int i = 0; i < 300; i++) send(mk(3'b111, i));
    tick(3);
    chk("drop_sat", 64'(drop_cnt), 64'd255);
    chk("rsvd_no_we", 64'(we_cnt - w0), 64'd0);
    chk("rsvd_no_spk", 64'(spk_cnt - s0), 64'd0);

    // Drain credits, park three flits, reset mid-cycle
    for (int i = 0; i < 6; i++) send(mk(3'b101, 'h400 + i));
    tick(4);
    chk("model_cfg_three", 64'(m_cfg.size()), 64'd3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 64'(spk_in_config_we), 64'd0);
    chk("rst_mid_spk_vld", 64'(spk_axon_vld), 64'd0);
    chk("rst_mid_err", 64'(credit_err), 64'd0);
    chk("rst_mid_drop", 64'(drop_cnt), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    w0 = we_cnt;
    tick(10);
    chk("post_rst_no_we", 64'(we_cnt - w0), 64'd0);
    for (int i = 0; i < 5; i++) send(mk(3'b110, 'h500 + i));
    tick(10);
    chk("post_rst_credits", 64'(we_cnt - w0), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
